// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I size codes, FSM states,
// beat-counter width and the funct3 legality check.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Wide enough to hold a beat count of 4 (misaligned word).
    localparam int BEAT_W = 3;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} lsu_state_t;

    function automatic logic f3_legal(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational sign/zero extension of assembled load data by RV32I size code.
module load_extend
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] raw,
    input  logic [2:0]            funct3,
    output logic [DATA_WIDTH-1:0] ext
);

    logic signed [BYTE_WIDTH-1:0]   byte_s;
    logic signed [2*BYTE_WIDTH-1:0] half_s;
    logic signed [DATA_WIDTH-1:0]   byte_x;
    logic signed [DATA_WIDTH-1:0]   half_x;

    assign byte_s = raw[BYTE_WIDTH-1:0];
    assign half_s = raw[2*BYTE_WIDTH-1:0];
    assign byte_x = DATA_WIDTH'(byte_s);
    assign half_x = DATA_WIDTH'(half_s);

    always_comb begin
        ext = raw;
        case (funct3)
            F3_B:    ext = byte_x;
            F3_H:    ext = half_x;
            F3_BU:   ext = {{(DATA_WIDTH-BYTE_WIDTH){1'b0}}, raw[BYTE_WIDTH-1:0]};
            F3_HU:   ext = {{(DATA_WIDTH-2*BYTE_WIDTH){1'b0}}, raw[2*BYTE_WIDTH-1:0]};
            default: ext = raw;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one request at a time, split into byte beats when needed.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned H/HU/W instead of splitting them.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [DATA_WIDTH-1:0] mem_a,
    output logic [DATA_WIDTH-1:0] mem_wd,
    output logic                  mem_addr_mode,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rd
);

    localparam int LANES = DATA_WIDTH / BYTE_WIDTH;

    lsu_state_t            state, state_nxt;
    logic [BEAT_W-1:0]     beat_p0, beat_nxt;
    logic [BEAT_W-1:0]     nbeats_in, nbeats_p0;
    logic                  byte_mode_in, err_in;
    logic                  we_p0, byte_mode_p0, err_p0;
    logic [2:0]            funct3_p0;
    logic [DATA_WIDTH-1:0] addr_p0, wdata_p0;
    logic [DATA_WIDTH-1:0] rdata_p1, ext;
    logic                  in_access;

    // Request decode: beat count, access mode and rejection
    always_comb begin
        nbeats_in    = BEAT_W'(1);
        byte_mode_in = 1'b1;
        err_in       = !f3_legal(req_funct3);
        case (req_funct3)
            F3_W: begin
                if (req_addr[1:0] == 2'b00) byte_mode_in = 1'b0;
                else                        nbeats_in    = BEAT_W'(LANES);
            end
            F3_H, F3_HU: nbeats_in = BEAT_W'(2);
            default: ;
        endcase
`ifdef LSU_MISALIGN_TRAP_EN
        if ((req_funct3 == F3_W && req_addr[1:0] != 2'b00) ||
            ((req_funct3 == F3_H || req_funct3 == F3_HU) && req_addr[0]))
            err_in = 1'b1;
`endif
    end

    always_comb begin
        state_nxt = state;
        beat_nxt  = beat_p0;
        case (state)
            IDLE: begin
                beat_nxt = '0;
                if (req_valid) state_nxt = err_in ? RESP : ACCESS;
            end
            ACCESS: begin
                if (beat_p0 == nbeats_p0 - BEAT_W'(1)) begin
                    state_nxt = RESP;
                    beat_nxt  = '0;
                end else begin
                    beat_nxt = beat_p0 + BEAT_W'(1);
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            beat_p0 <= '0;
        end else begin
            state   <= state_nxt;
            beat_p0 <= beat_nxt;
        end
    end

    // Capture stage (p0) and load assembly stage (p1); data only, no reset
    always_ff @(posedge clk) begin
        if (state == IDLE && req_valid) begin
            we_p0        <= req_we;
            funct3_p0    <= req_funct3;
            addr_p0      <= req_addr;
            wdata_p0     <= req_wdata;
            nbeats_p0    <= nbeats_in;
            byte_mode_p0 <= byte_mode_in;
            err_p0       <= err_in;
        end
        if (state == ACCESS && !we_p0) begin
            if (byte_mode_p0) rdata_p1[beat_p0*BYTE_WIDTH +: BYTE_WIDTH] <= mem_rd[BYTE_WIDTH-1:0];
            else              rdata_p1 <= mem_rd;
        end
    end

    load_extend #(
        .DATA_WIDTH(DATA_WIDTH),
        .BYTE_WIDTH(BYTE_WIDTH)
    ) u_load_extend (
        .raw   (rdata_p1),
        .funct3(funct3_p0),
        .ext   (ext)
    );

    // Memory port is idle-zero outside ACCESS
    assign in_access     = (state == ACCESS);
    assign mem_we        = in_access && we_p0;
    assign mem_addr_mode = in_access && byte_mode_p0;
    assign mem_a         = in_access ? addr_p0 + DATA_WIDTH'(beat_p0) : '0;
    assign mem_wd        = !in_access  ? '0 :
                           byte_mode_p0 ? {{(DATA_WIDTH-BYTE_WIDTH){1'b0}},
                                           wdata_p0[beat_p0*BYTE_WIDTH +: BYTE_WIDTH]}
                                        : wdata_p0;

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_err   = (state == RESP) && err_p0;
    assign resp_rdata = (state == RESP && !we_p0 && !err_p0) ? ext : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a byte-addressed memory model
// (256-byte window aliased over the address space) and a reference model.
module tb_load_store_unit;

    localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010, BU = 3'b100, HU = 3'b101;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic        req_ready;
    logic [2:0]  req_funct3 = 3'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        resp_valid, resp_err, mem_addr_mode, mem_we;
    logic [31:0] resp_rdata, mem_a, mem_wd, mem_rd;

    logic [7:0]  mem     [256];
    logic [7:0]  ref_mem [256];
    logic        pre_we = 1'b0;
    logic [7:0]  pre_a = '0, pre_d = '0;
    logic [7:0]  ma;

    int total = 0;
    int bad   = 0;

    load_store_unit dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_a(mem_a), .mem_wd(mem_wd), .mem_addr_mode(mem_addr_mode),
        .mem_we(mem_we), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    assign ma     = mem_a[7:0];
    assign mem_rd = mem_addr_mode ? {24'b0, mem[ma]}
                                  : {mem[ma+8'd3], mem[ma+8'd2], mem[ma+8'd1], mem[ma]};

    always @(posedge clk) begin
        if (mem_we) begin
            if (mem_addr_mode) mem[ma] <= mem_wd[7:0];
            else for (int i = 0; i < 4; i++) mem[ma + 8'(i)] <= mem_wd[8*i +: 8];
        end else if (pre_we) begin
            mem[pre_a] <= pre_d;
        end
    end

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_a = a; pre_d = d;
        ref_mem[a] = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Reference model: size from code, alignment rules, byte-wise data
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output int n, output int size,
                         output bit err, output bit bmode, output logic [31:0] rdata);
        bit legal, mis, trap;
        logic [31:0] val;
        legal = (f3 == B) || (f3 == BU) || (f3 == H) || (f3 == HU) || (f3 == W);
        size  = (f3 == W) ? 4 : (f3 == H || f3 == HU) ? 2 : 1;
`ifdef LSU_MISALIGN_TRAP_EN
        trap = 1'b1;
`else
        trap = 1'b0;
`endif
        mis   = (size == 2 && addr[0]) || (size == 4 && addr[1:0] != 2'b00);
        err   = !legal || (trap && mis);
        bmode = !(size == 4 && !mis);
        n     = err ? 0 : (bmode ? size : 1);
        rdata = '0;
        if (!err && we) begin
            for (int i = 0; i < size; i++) ref_mem[8'(addr + i)] = 8'(wdata >> (8 * i));
        end else if (!err) begin
            val = '0;
            for (int i = 0; i < size; i++) val = val + (32'(ref_mem[8'(addr + i)]) << (8 * i));
            rdata = val;
            if (f3 == B && val >= 32'h80)   rdata = val - 32'h100;
            if (f3 == H && val >= 32'h8000) rdata = val - 32'h10000;
        end
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] got_rdata,
                          output logic got_err, output int got_beats);
        int n, size;
        bit err, bmode, seen;
        logic [31:0] exp_rdata, exp_wd;
        model(we, f3, addr, wdata, n, size, err, bmode, exp_rdata);
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1 || mem_we !== 1'b0 || resp_valid !== 1'b0 || mem_a !== 32'h0) begin
            bad++;
            $display("FAIL idle: ready=%b we=%b resp_valid=%b mem_a=%h required 1 0 0 0",
                     req_ready, mem_we, resp_valid, mem_a);
        end
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        @(negedge clk);
        req_valid = 1'($urandom); req_we = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        got_beats = 0; seen = 1'b0; got_rdata = '0; got_err = 1'b0;
        for (int c = 1; c <= 8 && !seen; c++) begin
            if (resp_valid === 1'b1) begin
                seen = 1'b1; got_rdata = resp_rdata; got_err = resp_err;
                req_valid = 1'b0;
                total++;
                if (c != n + 1 || got_beats != n) begin
                    bad++;
                    $display("FAIL latency: resp at cycle %0d after %0d beats, required cycle %0d and %0d beats",
                             c, got_beats, n + 1, n);
                end
                total++;
                if (resp_err !== err || resp_rdata !== exp_rdata) begin
                    bad++;
                    $display("FAIL resp f3=%b addr=%h: err=%b rdata=%h required err=%b rdata=%h",
                             f3, addr, resp_err, resp_rdata, err, exp_rdata);
                end
                total++;
                if (req_ready !== 1'b0 || mem_we !== 1'b0 || mem_a !== 32'h0 || mem_wd !== 32'h0) begin
                    bad++;
                    $display("FAIL resp_port: ready=%b we=%b a=%h wd=%h required all 0",
                             req_ready, mem_we, mem_a, mem_wd);
                end
            end else begin
                exp_wd = bmode ? ((wdata >> (8 * got_beats)) & 32'hFF) : wdata;
                total++;
                if (mem_we !== we || mem_a !== addr + 32'(got_beats) || mem_addr_mode !== bmode ||
                    mem_wd !== exp_wd || req_ready !== 1'b0 || resp_err !== 1'b0) begin
                    bad++;
                    $display("FAIL beat%0d: we=%b a=%h mode=%b wd=%h ready=%b err=%b required we=%b a=%h mode=%b wd=%h ready=0 err=0",
                             got_beats, mem_we, mem_a, mem_addr_mode, mem_wd, req_ready, resp_err,
                             we, addr + 32'(got_beats), bmode, exp_wd);
                end
                got_beats++;
                @(negedge clk);
            end
        end
        if (!seen) begin
            total++; bad++;
            req_valid = 1'b0;
            $display("FAIL timeout: no resp_valid within 8 cycles, required at cycle %0d", n + 1);
        end
        if (we && !err) begin
            for (int i = 0; i < size; i++) begin
                total++;
                if (mem[8'(addr + i)] !== ref_mem[8'(addr + i)]) begin
                    bad++;
                    $display("FAIL store_byte addr=%h: got %h required %h",
                             addr + i, mem[8'(addr + i)], ref_mem[8'(addr + i)]);
                end
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        total++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0 ||
            mem_a !== 32'h0 || mem_wd !== 32'h0 || mem_addr_mode !== 1'b0 || mem_we !== 1'b0) begin
            bad++;
            $display("FAIL %s: ready=%b rv=%b rd=%h err=%b a=%h wd=%h mode=%b we=%b required 1 0 0 0 0 0 0 0",
                     tag, req_ready, resp_valid, resp_rdata, resp_err, mem_a, mem_wd, mem_addr_mode, mem_we);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req_valid = 1'b1; req_funct3 = W; req_we = 1'b1;
        for (int i = 0; i < 256; i++) poke(8'(i), 8'($urandom));
        check_reset_outputs("reset_held");
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("after_reset");
    endtask

    task automatic test_aligned_word;
        logic [31:0] r; logic e; int b;
        poke(8'h00, 8'h78); poke(8'h01, 8'h56); poke(8'h02, 8'h34); poke(8'h03, 8'h12);
        do_req(1'b0, W, 32'h0001_0000, 32'h0, r, e, b);
        total++;
        if (r !== 32'h1234_5678 || e !== 1'b0 || b != 1) begin
            bad++; $display("FAIL lw_aligned: rdata=%h err=%b beats=%0d required 12345678 0 1", r, e, b);
        end
    endtask

    task automatic test_byte_ext;
        logic [31:0] r; logic e; int b;
        poke(8'h03, 8'h80);
        do_req(1'b0, B, 32'h0001_0003, 32'h0, r, e, b);
        total++;
        if (r !== 32'hFFFF_FF80 || b != 1) begin
            bad++; $display("FAIL lb_sign: rdata=%h beats=%0d required ffffff80 1", r, b);
        end
        do_req(1'b0, BU, 32'h0001_0003, 32'h0, r, e, b);
        total++;
        if (r !== 32'h0000_0080 || b != 1) begin
            bad++; $display("FAIL lbu_zero: rdata=%h beats=%0d required 00000080 1", r, b);
        end
    endtask

    task automatic test_misaligned_store;
        logic [31:0] r; logic e; int b;
        do_req(1'b1, W, 32'h0001_0001, 32'hAABB_CCDD, r, e, b);
`ifdef LSU_MISALIGN_TRAP_EN
        total++;
        if (e !== 1'b1 || b != 0) begin
            bad++; $display("FAIL sw_mis_trap: err=%b beats=%0d required 1 0", e, b);
        end
`else
        total++;
        if (b != 4 || mem[1] !== 8'hDD || mem[2] !== 8'hCC || mem[3] !== 8'hBB || mem[4] !== 8'hAA) begin
            bad++; $display("FAIL sw_mis: beats=%0d bytes=%h %h %h %h required 4 dd cc bb aa",
                            b, mem[1], mem[2], mem[3], mem[4]);
        end
        do_req(1'b0, W, 32'h0001_0001, 32'h0, r, e, b);
        total++;
        if (r !== 32'hAABB_CCDD || b != 4) begin
            bad++; $display("FAIL lw_mis: rdata=%h beats=%0d required aabbccdd 4", r, b);
        end
`endif
    endtask

    task automatic test_misaligned_half;
        logic [31:0] r; logic e; int b;
        poke(8'h01, 8'hDD); poke(8'h02, 8'hCC);
        do_req(1'b0, H, 32'h0001_0001, 32'h0, r, e, b);
`ifdef LSU_MISALIGN_TRAP_EN
        total++;
        if (e !== 1'b1 || r !== 32'h0 || b != 0) begin
            bad++; $display("FAIL lh_trap: err=%b rdata=%h beats=%0d required 1 0 0", e, r, b);
        end
`else
        total++;
        if (e !== 1'b0 || r !== 32'hFFFF_CCDD || b != 2) begin
            bad++; $display("FAIL lh_split: err=%b rdata=%h beats=%0d required 0 ffffccdd 2", e, r, b);
        end
`endif
    endtask

    task automatic test_wrap_illegal;
        logic [31:0] r; logic e; int b;
        do_req(1'b1, H, 32'hFFFF_FFFF, 32'h0000_1234, r, e, b);
`ifndef LSU_MISALIGN_TRAP_EN
        total++;
        if (b != 2 || mem[8'hFF] !== 8'h34 || mem[8'h00] !== 8'h12) begin
            bad++; $display("FAIL sh_wrap: beats=%0d ff=%h 00=%h required 2 34 12", b, mem[8'hFF], mem[8'h00]);
        end
`endif
        do_req(1'b0, 3'b011, 32'h0001_0000, 32'h0, r, e, b);
        total++;
        if (e !== 1'b1 || r !== 32'h0 || b != 0) begin
            bad++; $display("FAIL illegal_f3: err=%b rdata=%h beats=%0d required 1 0 0", e, r, b);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] r, addr; logic e; int b;
        logic [2:0] codes [8] = '{B, H, W, BU, HU, 3'b011, 3'b110, 3'b111};
        logic [31:0] bases [3] = '{32'h0001_0000, 32'hFFFF_FF00, 32'h0};
        int k;
        for (int i = 0; i < 60; i++) begin
            k    = $urandom_range(0, 10);
            addr = bases[$urandom_range(0, 2)] | 32'($urandom_range(0, 255));
            do_req(1'($urandom), (k > 7) ? W : codes[k], addr, $urandom, r, e, b);
        end
    endtask

    task automatic test_reset_midop;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = W;
        req_addr = 32'h0001_0021; req_wdata = 32'h1122_3344;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
`ifndef LSU_MISALIGN_TRAP_EN
        total++;
        if (mem_we !== 1'b1 || mem_a !== 32'h0001_0023) begin
            bad++; $display("FAIL midop_beat2: we=%b a=%h required 1 00010023", mem_we, mem_a);
        end
`endif
        @(negedge clk);
        check_reset_outputs("midop_reset");
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
                bad++; $display("FAIL midop_after: resp_valid=%b ready=%b required 0 1", resp_valid, req_ready);
            end
        end
`ifndef LSU_MISALIGN_TRAP_EN
        total++;
        if (mem[8'h21] !== 8'h44 || mem[8'h22] !== 8'h33) begin
            bad++; $display("FAIL midop_bytes: %h %h required 44 33", mem[8'h21], mem[8'h22]);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_aligned_word();
        test_byte_ext();
        test_misaligned_store();
        test_misaligned_half();
        test_wrap_illegal();
        test_back_to_back();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1);
    end

endmodule
